alu_pipe_n: RTL and testbench

ALU_PIPE_N -- requirements
Module: alu_pipe_n

---
 rtl/alu_pipe_n.sv | 214 +++++++++++++++++++++
 tb/tb_alu_pipe_n.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_n.sv
// alu_pipe_n: single-issue ALU with valid/ready handshakes on both sides.
// add/sub/and/or/shl/sra/invalid complete one cycle after accept, and a
// result can be retired while the next op is accepted on the same edge.
// Build option: define ALU_PIPE_MUL_EN to add an unsigned shift-add
// multiplier (sel=110) that takes WIDTH cycles in the EXEC state. When the
// macro is not defined, sel=110 completes as an invalid opcode.
module alu_pipe_n #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [1:0] IDLE = 2'd0;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [1:0] EXEC = 2'd1;
`endif
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b110;
`endif

  logic [1:0]       state_q, state_d;
  logic             accept;
  logic             is_mul;

  logic [WIDTH:0]   add_sum, sub_sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c, alu_v, alu_e;

  logic [WIDTH-1:0] y_d;
  logic             c_d, z_d, n_d, v_d, e_d, ov_d;

`ifdef ALU_PIPE_MUL_EN
  localparam int unsigned PW = 2 * WIDTH;
  logic [PW-1:0]    acc_q, acc_d, mcand_q, mcand_d, prod;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  assign is_mul = (sel == OP_MUL);
  // One partial product per EXEC cycle, LSB of the multiplier first.
  assign prod   = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign is_mul = 1'b0;
`endif

  // Upstream can hand over a new op when idle, or when the held result is
  // being retired this cycle (combinational on out_ready).
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle ALU datapath on the raw inputs.
  always_comb begin
    shamt   = B[SHW-1:0];
    add_sum = {1'b0, A} + {1'b0, B};
    sub_sum = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (sel)
      OP_ADD: begin
        alu_y = add_sum[WIDTH-1:0];
        alu_c = add_sum[WIDTH];
        alu_v = (A[MSB] == B[MSB]) && (add_sum[MSB] != A[MSB]);
      end
      OP_SUB: begin
        alu_y = sub_sum[WIDTH-1:0];
        alu_c = sub_sum[WIDTH];
        alu_v = (A[MSB] != B[MSB]) && (sub_sum[MSB] != A[MSB]);
      end
      OP_AND:  alu_y = A & B;
      OP_OR:   alu_y = A | B;
      OP_SHL:  alu_y = A << shamt;
      OP_SRA:  alu_y = $unsigned($signed(A) >>> shamt);
      default: alu_e = 1'b1;
    endcase
  end

  // Next-state and next-output logic; everything holds unless updated.
  always_comb begin
    state_d = state_q;
    y_d     = Y;
    c_d     = Cout;
    z_d     = Z;
    n_d     = N;
    v_d     = V;
    e_d     = err;
    ov_d    = out_valid;
`ifdef ALU_PIPE_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept && !is_mul) begin
          state_d = DONE;
          ov_d    = 1'b1;
          y_d     = alu_y;
          c_d     = alu_c;
          z_d     = (alu_y == '0);
          n_d     = alu_y[MSB];
          v_d     = alu_v;
          e_d     = alu_e;
        end
`ifdef ALU_PIPE_MUL_EN
        else if (accept) begin
          state_d  = EXEC;
          ov_d     = 1'b0;
          acc_d    = '0;
          mcand_d  = PW'(A);
          mplier_d = B;
          cnt_d    = '0;
        end
`endif
        else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
          ov_d    = 1'b0;
        end
      end
`ifdef ALU_PIPE_MUL_EN
      EXEC: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = DONE;
          ov_d    = 1'b1;
          y_d     = prod[WIDTH-1:0];
          c_d     = |prod[PW-1:WIDTH];
          z_d     = (prod[WIDTH-1:0] == '0);
          n_d     = prod[MSB];
          v_d     = 1'b0;
          e_d     = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Registered result and flags; reset clears everything, Z included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y         <= '0;
      Cout      <= 1'b0;
      Z         <= 1'b0;
      N         <= 1'b0;
      V         <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      Y         <= y_d;
      Cout      <= c_d;
      Z         <= z_d;
      N         <= n_d;
      V         <= v_d;
      err       <= e_d;
      out_valid <= ov_d;
    end
  end

`ifdef ALU_PIPE_MUL_EN
  // Multiplier working registers; operands are captured at accept so input
  // changes during EXEC have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe_n.sv
// Scoreboard bench for alu_pipe_n at WIDTH=8. Stimulus pushes hand-computed
// expectations; a negedge monitor pops and compares on every retirement.
module tb_alu_pipe_n;
  localparam int unsigned W = 8;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] SHL = 3'b100, SRA = 3'b101, MUL = 3'b110, INV = 3'b111;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, y;
  logic [2:0]   sel;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic         cout, z, n, v, err;

  alu_pipe_n #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .Y(y), .Cout(cout), .Z(z), .N(n), .V(v), .err(err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] y;
    logic         c, z, n, v, e;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: one pop per retirement (out_valid && out_ready at the edge).
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", 64'(y), 64'hDEAD);
      end else begin
        m = q.pop_front();
        check({m.tag, "_res"}, 64'({y, cout, z, n, v, err}),
              64'({m.y, m.c, m.z, m.n, m.v, m.e}));
        if (m.lat != 0) check({m.tag, "_lat"}, 64'(cyc - m.acc + 1), 64'(m.lat));
      end
    end
  end

  // Present one op, wait for the accepting edge, push its expectation.
  task automatic issue(input string tag, input logic [2:0] s, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic [W-1:0] ey, input logic ec,
                       input logic ez, input logic en, input logic ev, input logic ee,
                       input int lat);
    int t;
    exp_t e;
    a = aa; b = bb; sel = s; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      check({tag, "_accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e.tag = tag; e.y = ey; e.c = ec; e.z = ez; e.n = en; e.v = ev; e.e = ee;
    e.lat = lat; e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 100) begin @(negedge clk); t++; end
    if (q.size() > 0) check("drain_timeout", 64'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int c0;
    rst = 1'b1; a = '0; b = '0; sel = ADD; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_outputs", 64'({out_valid, y, cout, z, n, v, err}), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 1);
    @(posedge clk); #1;

    // Directed vectors: tag, sel, A, B, Y, Cout, Z, N, V, err, latency
    issue("add_ff_01",  ADD,  8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 0, 1);
    issue("sub_80_01",  SUB,  8'h80, 8'h01, 8'h7F, 1, 0, 0, 1, 0, 1);
    issue("sra_90_3",   SRA,  8'h90, 8'h03, 8'hF2, 0, 0, 1, 0, 0, 1);
    issue("shl_81_1",   SHL,  8'h81, 8'h01, 8'h02, 0, 0, 0, 0, 0, 1);
    issue("and_f0_3c",  AND_, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 0, 1);
    issue("or_0f_a0",   OR_,  8'h0F, 8'hA0, 8'hAF, 0, 0, 1, 0, 0, 1);
    issue("add_7f_01",  ADD,  8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 0, 1);
    issue("sub_05_07",  SUB,  8'h05, 8'h07, 8'hFE, 0, 0, 1, 0, 0, 1);
    issue("sub_05_05",  SUB,  8'h05, 8'h05, 8'h00, 1, 1, 0, 0, 0, 1);
    issue("sra_80_7",   SRA,  8'h80, 8'h07, 8'hFF, 0, 0, 1, 0, 0, 1);
    issue("shl_01_7",   SHL,  8'h01, 8'h0F, 8'h80, 0, 0, 1, 0, 0, 1);
    issue("inv_111",    INV,  8'h12, 8'h34, 8'h00, 0, 1, 0, 0, 1, 1);
    drain();

    // Back-to-back adds: one accept per cycle, results in order.
    issue("b2b_0", ADD, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0, 0, 1);
    c0 = cyc;
    issue("b2b_1", ADD, 8'h10, 8'h20, 8'h30, 0, 0, 0, 0, 0, 1);
    issue("b2b_2", ADD, 8'h7F, 8'h7F, 8'hFE, 0, 0, 1, 1, 0, 1);
    issue("b2b_3", ADD, 8'hFF, 8'hFF, 8'hFE, 1, 0, 1, 0, 0, 1);
    check("b2b_rate", 64'(cyc - c0), 3);
    drain();

    // Backpressure: result and flags hold, in_ready low, new op not taken.
    out_ready = 1'b0;
    issue("hold", ADD, 8'h03, 8'h04, 8'h07, 0, 0, 0, 0, 0, 0);
    a = 8'hAA; b = 8'h55; sel = ADD; in_valid = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (y !== 8'h07 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("hold_3cyc", 64'(bad), 0);
    in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

`ifdef ALU_PIPE_MUL_EN
    issue("mul_10_11", MUL, 8'h10, 8'h11, 8'h10, 1, 0, 0, 0, 0, W + 1);
    a = 8'h00; b = 8'h00;
    bad = 0;
    repeat (W) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    check("mul_exec_busy", 64'(bad), 0);
    drain();
    issue("mul_ff_ff", MUL, 8'hFF, 8'hFF, 8'h01, 1, 0, 0, 0, 0, W + 1);
    issue("mul_03_05", MUL, 8'h03, 8'h05, 8'h0F, 0, 0, 0, 0, 0, W + 1);
    drain();
    // Reset during the 4th EXEC cycle aborts the multiply.
    issue("mul_abort", MUL, 8'h0F, 8'h0F, 8'hE1, 0, 0, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
`else
    issue("sel110_inv", MUL, 8'h10, 8'h11, 8'h00, 0, 1, 0, 0, 1, 1);
    drain();
    // Reset while a result is held aborts it.
    out_ready = 1'b0;
    issue("held_abort", ADD, 8'h01, 8'h01, 8'h02, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
`endif
    q.delete();
    #1 check("abort_rst_out", 64'({out_valid, y, cout, z, n, v, err}), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(in_ready), 1);
    bad = 0;
    repeat (W + 2) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    check("abort_no_result", 64'(bad), 0);
    @(posedge clk); #1;
    issue("add_after_abort", ADD, 8'h22, 8'h33, 8'h55, 0, 0, 0, 0, 0, 1);
    drain();

    check("queue_empty", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
